// File: rtl/cpu_pkg.sv
// Shared definitions for the memory-access stage: FSM states, mem_ctl encodings
// and the default bus timeout.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_DONE = 2'b11
  } mem_state_e;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_STORE = 2'b01;
  localparam logic [1:0] MEM_LOAD  = 2'b10;
  localparam logic [1:0] MEM_RSVD  = 2'b11;

  localparam int TIMEOUT_CYC_DEF = 255;

  // Encoding 11 is reserved and behaves like "no memory op".
  function automatic logic is_mem_op(input logic valid, input logic [1:0] ctl);
    return valid && ((ctl == MEM_STORE) || (ctl == MEM_LOAD));
  endfunction

endpackage

// File: rtl/mem_timeout.sv
// Bus-wait watchdog: down-counter reloaded by clear, decremented by enable;
// expired flags the TIMEOUT_CYC-th enabled cycle.
module mem_timeout
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD_VAL;
    end else if (clear) begin
      cnt <= LOAD_VAL;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = enable && (cnt == '0);

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues loads/stores on the data bus, stalls upstream while
// waiting, and loads the MEM/WB register. MEM_ALIGN_CHECK_EN enables misalignment faults.
//
// state | meaning
// IDLE  | pass non-memory slots through; start a bus access for loads/stores
// REQ   | bus_req held until bus_ready handshake
// RESP  | load accepted, waiting for bus_rvalid
// DONE  | access finished (or timed out); MEM/WB loads from held slot
module mem_access
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [1:0]  wb_in,
  input  logic [1:0]  mem_ctl,
  input  logic [31:0] alu_in,
  input  logic [31:0] wdata_in,
  input  logic [4:0]  rd_in,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        valid_out,
  output logic [1:0]  wb_out,
  output logic [4:0]  rd_out,
  output logic [31:0] alu_out,
  output logic [31:0] rdata_out,
  output logic        err
);

  mem_state_e state_q, state_d;

  logic        mem_op;
  logic        misaligned;
  logic        start;
  logic        expired;
  logic        tmo_clear;
  logic        tmo_enable;
  logic        timeout_hit;

  logic        hold_valid;
  logic [1:0]  hold_wb;
  logic [4:0]  hold_rd;
  logic [31:0] hold_alu;
  logic [31:0] hold_wdata;
  logic        hold_we;
  logic [31:0] rdata_q;
  logic        timed_out;

  assign mem_op = is_mem_op(valid_in, mem_ctl);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = mem_op && (alu_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign start = (state_q == ST_IDLE) && mem_op && !misaligned;

  assign tmo_clear  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign tmo_enable = (state_q == ST_REQ) || (state_q == ST_RESP);

  mem_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (expired)
  );

  // A handshake landing in the expiry cycle still wins over the timeout.
  assign timeout_hit = expired &&
                       !(((state_q == ST_REQ) && bus_ready) ||
                         ((state_q == ST_RESP) && bus_rvalid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    bus_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          stall   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_ready) begin
          state_d = hold_we ? ST_DONE : ST_RESP;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_RESP: begin
        stall = 1'b1;
        if (bus_rvalid || timeout_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus_addr  = hold_alu;
  assign bus_we    = bus_req && hold_we;
  assign bus_wdata = bus_req ? hold_wdata : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_wb    <= 2'b00;
      hold_rd    <= 5'd0;
      hold_alu   <= 32'h0;
      hold_wdata <= 32'h0;
      hold_we    <= 1'b0;
      rdata_q    <= 32'h0;
      timed_out  <= 1'b0;
      valid_out  <= 1'b0;
      wb_out     <= 2'b00;
      rd_out     <= 5'd0;
      alu_out    <= 32'h0;
      rdata_out  <= 32'h0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            hold_valid <= valid_in;
            hold_wb    <= wb_in;
            hold_rd    <= rd_in;
            hold_alu   <= alu_in;
            hold_wdata <= wdata_in;
            hold_we    <= (mem_ctl == MEM_STORE);
            rdata_q    <= 32'h0;
            timed_out  <= 1'b0;
            valid_out  <= 1'b0;
            wb_out     <= 2'b00;
          end else begin
            valid_out <= valid_in;
            wb_out    <= (valid_in && !misaligned) ? wb_in : 2'b00;
            rd_out    <= rd_in;
            alu_out   <= alu_in;
            rdata_out <= 32'h0;
            err       <= misaligned;
          end
        end
        ST_REQ, ST_RESP: begin
          // MEM/WB sees bubbles while the bus access is outstanding.
          valid_out <= 1'b0;
          wb_out    <= 2'b00;
          if ((state_q == ST_RESP) && bus_rvalid) begin
            rdata_q <= bus_rdata;
          end
          if (timeout_hit) begin
            timed_out <= 1'b1;
          end
        end
        ST_DONE: begin
          valid_out <= hold_valid;
          wb_out    <= (hold_valid && !timed_out) ? hold_wb : 2'b00;
          rd_out    <= hold_rd;
          alu_out   <= hold_alu;
          rdata_out <= (!hold_we && !timed_out) ? rdata_q : 32'h0;
          err       <= timed_out;
        end
        default: begin
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (TIMEOUT_CYC=4); covers the MEM_ALIGN_CHECK_EN
// build and the default build.
module tb_mem_access;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [1:0]  wb_in;
  logic [1:0]  mem_ctl;
  logic [31:0] alu_in;
  logic [31:0] wdata_in;
  logic [4:0]  rd_in;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        valid_out;
  logic [1:0]  wb_out;
  logic [4:0]  rd_out;
  logic [31:0] alu_out;
  logic [31:0] rdata_out;
  logic        err;

  int checks = 0;
  int errors = 0;
  int stall_hi = 0;

  mem_access #(.TIMEOUT_CYC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .wb_in      (wb_in),
    .mem_ctl    (mem_ctl),
    .alu_in     (alu_in),
    .wdata_in   (wdata_in),
    .rd_in      (rd_in),
    .stall      (stall),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .valid_out  (valid_out),
    .wb_out     (wb_out),
    .rd_out     (rd_out),
    .alu_out    (alu_out),
    .rdata_out  (rdata_out),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input logic v, input logic [1:0] ctl, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input logic [1:0] wb);
    valid_in = v;
    mem_ctl  = ctl;
    alu_in   = a;
    wdata_in = wd;
    rd_in    = rd;
    wb_in    = wb;
  endtask

  initial begin
    rst_n      = 1'b0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;
    set_slot(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 2'b00);
    #3;
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    #9 rst_n = 1'b1;
    step();

    // Plain ALU op passes through in one edge.
    set_slot(1'b1, 2'b00, 32'h10, 32'h0, 5'd5, 2'b01);
    #1;
    check("nop_stall", 32'(stall), 32'd0);
    step();
    check("nop_alu_out", alu_out, 32'h10);
    check("nop_rd_out", 32'(rd_out), 32'd5);
    check("nop_wb_out", 32'(wb_out), 32'd1);
    check("nop_valid_out", 32'(valid_out), 32'd1);

    // Reserved mem_ctl=11 behaves as no memory op.
    set_slot(1'b1, 2'b11, 32'h44, 32'h0, 5'd7, 2'b10);
    #1;
    check("rsvd_stall", 32'(stall), 32'd0);
    check("rsvd_bus_req", 32'(bus_req), 32'd0);
    step();
    check("rsvd_wb_out", 32'(wb_out), 32'd2);
    check("rsvd_alu_out", alu_out, 32'h44);

    // Empty slot: valid_out low squashes write-back.
    set_slot(1'b0, 2'b00, 32'h48, 32'h0, 5'd8, 2'b11);
    step();
    check("bubble_valid_out", 32'(valid_out), 32'd0);
    check("bubble_wb_out", 32'(wb_out), 32'd0);

    // Load 0x100: ready in 2nd REQ cycle, rvalid in 1st RESP cycle.
    set_slot(1'b1, 2'b10, 32'h100, 32'h0, 5'd3, 2'b01);
    #1;
    if (stall) stall_hi++;
    check("ld_idle_bus_req", 32'(bus_req), 32'd0);
    step();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hBADBAD00;
    #1;
    if (stall) stall_hi++;
    check("ld_req_bus_req", 32'(bus_req), 32'd1);
    check("ld_req_bus_addr", bus_addr, 32'h100);
    check("ld_req_bus_we", 32'(bus_we), 32'd0);
    step();
    bus_rvalid = 1'b0;
    bus_ready  = 1'b1;
    #1;
    if (stall) stall_hi++;
    check("ld_req2_bus_req", 32'(bus_req), 32'd1);
    step();
    bus_ready  = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hDEADBEEF;
    #1;
    if (stall) stall_hi++;
    check("ld_resp_bus_req", 32'(bus_req), 32'd0);
    check("ld_resp_valid_out", 32'(valid_out), 32'd0);
    step();
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;
    #1;
    if (stall) stall_hi++;
    check("ld_done_stall", 32'(stall), 32'd0);
    step();
    set_slot(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 2'b00);
    check("ld_rdata_out", rdata_out, 32'hDEADBEEF);
    check("ld_wb_out", 32'(wb_out), 32'd1);
    check("ld_rd_out", 32'(rd_out), 32'd3);
    check("ld_alu_out", alu_out, 32'h100);
    check("ld_valid_out", 32'(valid_out), 32'd1);
    check("ld_err", 32'(err), 32'd0);
    check("ld_stall_cycles", 32'(stall_hi), 32'd4);

    // Store 0x200, ready immediately.
    set_slot(1'b1, 2'b01, 32'h200, 32'h12345678, 5'd9, 2'b10);
    #1;
    check("st_idle_stall", 32'(stall), 32'd1);
    step();
    bus_ready = 1'b1;
    #1;
    check("st_bus_req", 32'(bus_req), 32'd1);
    check("st_bus_we", 32'(bus_we), 32'd1);
    check("st_bus_wdata", bus_wdata, 32'h12345678);
    check("st_bus_addr", bus_addr, 32'h200);
    step();
    bus_ready = 1'b0;
    #1;
    check("st_done_bus_we", 32'(bus_we), 32'd0);
    check("st_done_bus_req", 32'(bus_req), 32'd0);
    check("st_done_stall", 32'(stall), 32'd0);
    check("st_done_valid_out", 32'(valid_out), 32'd0);
    step();
    set_slot(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 2'b00);
    check("st_valid_out", 32'(valid_out), 32'd1);
    check("st_wb_out", 32'(wb_out), 32'd2);
    check("st_rd_out", 32'(rd_out), 32'd9);
    check("st_rdata_out", rdata_out, 32'h0);
    check("st_err", 32'(err), 32'd0);

    // Load that never gets bus_ready: 4 REQ cycles, then squashed completion.
    set_slot(1'b1, 2'b10, 32'h300, 32'h0, 5'd4, 2'b01);
    step();
    for (int i = 0; i < 4; i++) begin
      check("to_req_bus_req", 32'(bus_req), 32'd1);
      check("to_req_err", 32'(err), 32'd0);
      step();
    end
    check("to_done_bus_req", 32'(bus_req), 32'd0);
    check("to_done_stall", 32'(stall), 32'd0);
    step();
    set_slot(1'b0, 2'b00, 32'h55, 32'h0, 5'd1, 2'b00);
    check("to_err", 32'(err), 32'd1);
    check("to_wb_out", 32'(wb_out), 32'd0);
    check("to_valid_out", 32'(valid_out), 32'd1);
    check("to_rdata_out", rdata_out, 32'h0);
    step();
    check("to_err_pulse", 32'(err), 32'd0);
    check("pre_rst_alu_out", alu_out, 32'h55);

    // Reset while waiting in RESP.
    set_slot(1'b1, 2'b10, 32'h100, 32'h0, 5'd6, 2'b01);
    step();
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    #1;
    check("rr_resp_stall", 32'(stall), 32'd1);
    set_slot(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 2'b00);
    #1 rst_n = 1'b0;
    #1;
    check("rr_bus_req", 32'(bus_req), 32'd0);
    check("rr_stall", 32'(stall), 32'd0);
    check("rr_valid_out", 32'(valid_out), 32'd0);
    check("rr_rd_out", 32'(rd_out), 32'd0);
    check("rr_alu_out", alu_out, 32'h0);
    check("rr_rdata_out", rdata_out, 32'h0);
    check("rr_err", 32'(err), 32'd0);
    #1 rst_n = 1'b1;
    step();

    // Misaligned store at 0x203.
    set_slot(1'b1, 2'b01, 32'h203, 32'hCAFEF00D, 5'd2, 2'b10);
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    check("mis_stall", 32'(stall), 32'd0);
    check("mis_bus_req", 32'(bus_req), 32'd0);
    step();
    set_slot(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 2'b00);
    check("mis_err", 32'(err), 32'd1);
    check("mis_wb_out", 32'(wb_out), 32'd0);
    check("mis_valid_out", 32'(valid_out), 32'd1);
    check("mis_alu_out", alu_out, 32'h203);
    check("mis_after_bus_req", 32'(bus_req), 32'd0);
    step();
    check("mis_err_pulse", 32'(err), 32'd0);
`else
    check("mis_stall", 32'(stall), 32'd1);
    step();
    bus_ready = 1'b1;
    #1;
    check("mis_bus_req", 32'(bus_req), 32'd1);
    check("mis_bus_addr", bus_addr, 32'h203);
    step();
    bus_ready = 1'b0;
    step();
    set_slot(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 2'b00);
    check("mis_wb_out", 32'(wb_out), 32'd2);
    check("mis_err", 32'(err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, max bus-wait cycles before abort.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port valid_in  in  1  EX/MEM slot holds a live instruction.
REQ-005 SHALL have port wb_in  in  2  write-back control from EX/MEM.
REQ-006 SHALL have port mem_ctl  in  2  memory op: 00 none, 01 store, 10 load, 11 treated as none.
REQ-007 SHALL have port alu_in  in  32  ALU result, used as byte address for loads and stores.
REQ-008 SHALL have port wdata_in  in  32  store data.
REQ-009 SHALL have port rd_in  in  5  destination register.
REQ-010 SHALL have port stall  out  1  freeze upstream pipeline; upstream holds all inputs while high.
REQ-011 SHALL have ports bus_req out 1, bus_we out 1, bus_addr out 32, bus_wdata out 32  data-bus request.
REQ-012 SHALL have ports bus_ready in 1 (request accepted), bus_rvalid in 1 (read data valid), bus_rdata in 32.
REQ-013 SHALL have outputs valid_out 1, wb_out 2, rd_out 5, alu_out 32, rdata_out 32  MEM/WB register.
REQ-014 SHALL have output err 1  one-cycle pulse on timeout or misalignment.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, RESP, DONE.
REQ-016 In IDLE with no memory op (valid_in=0 or mem_ctl in {00,11}), SHALL load the MEM/WB outputs from the inputs at the next edge (latency 1) with stall=0.
REQ-017 In IDLE with valid_in=1 and mem_ctl in {01,10}, SHALL drive stall=1 combinationally and enter REQ at the next edge.
REQ-018 In REQ, SHALL hold bus_req=1 and keep bus_addr, bus_we and bus_wdata stable until the edge where bus_ready=1.
REQ-019 On a store handshake, SHALL go to DONE; on a load handshake, SHALL go to RESP.
REQ-020 In RESP, SHALL capture bus_rdata on the edge where bus_rvalid=1 and go to DONE; bus_rvalid outside RESP SHALL be ignored.
REQ-021 In REQ and RESP, SHALL keep stall=1; in DONE, SHALL drive stall=0.
REQ-022 In DONE, SHALL load the MEM/WB outputs from the held inputs plus captured data at the next edge, then return to IDLE.
- Memory-op latency = bus wait cycles + 2.
REQ-023 SHALL drive rdata_out with the captured load data for loads and 0 otherwise; alu_out SHALL equal alu_in.
REQ-024 SHALL count cycles spent in REQ and RESP; on reaching TIMEOUT_CYC, SHALL drop bus_req and enter DONE.
- In that case: wb_out=00 (write-back squashed), rdata_out=0, err pulsed for one cycle.
REQ-025 valid_out SHALL follow valid_in for the slot being loaded; when valid_out=0, wb_out SHALL be 00.

Reset
REQ-026 rst_n low SHALL force IDLE, clear the timeout counter, and set bus_req=0, valid_out=0, wb_out=0, rd_out=0, alu_out=0, rdata_out=0, err=0.
- Applies mid-transaction; an in-flight bus transfer is abandoned.

Configuration
REQ-027 With MEM_ALIGN_CHECK_EN defined:
- a load or store with alu_in[1:0]!=00 SHALL issue no bus request;
- SHALL complete in 1 cycle with wb_out=00, rdata_out=0 and an err pulse.
REQ-028 Without MEM_ALIGN_CHECK_EN, SHALL pass the address to bus_addr unchecked, and err SHALL assert only on timeout.

Structure
REQ-029 SHALL place the FSM state enum, the mem_ctl encodings and the default TIMEOUT_CYC in shared package cpu_pkg.
REQ-030 SHALL keep the timeout counter as sub-module mem_timeout (inputs: clear, enable; output: expired).

Verification
REQ-031 Non-memory op (mem_ctl=00, alu_in=0x10, rd_in=5, wb_in=01): after 1 edge -> alu_out=0x10, rd_out=5, wb_out=01, stall never high.
REQ-032 Load at address 0x100, bus_ready 2 cycles after request, bus_rvalid 1 cycle later with data 0xDEADBEEF -> rdata_out=0xDEADBEEF, stall high 4 cycles.
REQ-033 Store at 0x200 with data 0x12345678, bus_ready immediate -> bus_we=1, bus_wdata=0x12345678 for 1 cycle, outputs valid 2 edges after the request cycle.
REQ-034 Load with bus_ready never asserted, TIMEOUT_CYC=4 -> err pulse after 4 cycles in REQ, wb_out=00, stall released.
REQ-035 rst_n low while in RESP -> bus_req=0, state IDLE, all outputs 0 immediately without waiting for a clock edge.
REQ-036 With MEM_ALIGN_CHECK_EN defined, store at 0x203 -> no bus_req, err pulse, wb_out=00, 1-cycle latency.
